// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register: state encoding and default width.
// No logic; the state values double as the occupancy count.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
// Latency: count updates on the edge after inc; clear wins over inc.
// Backpressure: none, the counter simply stops at all-ones.
module pipe_sat_ctr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid); optional stall counter under PIPE_SKID_STALL_CNT_EN.
// Latency: 1 cycle from in_fire to out_valid when empty; out_data and in_ready are registered.
// Backpressure: skid entry absorbs one word so in_ready never depends combinationally on out_ready.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W  = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = en & in_valid & in_ready_q;
    assign out_fire  = en & out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= RST_VAL;
            skid_q     <= RST_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_q;
    assign occ      = state_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    // Flush does not clear the stall history; only reset does
    pipe_sat_ctr #(
        .WIDTH (32)
    ) u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (en & out_valid & ~out_ready),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..1024.
REQ-002 The block SHALL have parameter RST_VAL, default 0 (DATA_W bits): the out_data value after reset and after flush.
REQ-003 The block SHALL have one clock, one reset and the ports listed below.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- en  input  1  stage enable; 0 freezes all state.
- flush  input  1  discard all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block can accept; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload; registered.
- occ  output  2  entries held: 0, 1 or 2.
- stall_cnt  output  32  output-stall cycle count; present only with PIPE_SKID_STALL_CNT_EN.

Function
REQ-004 The block SHALL define in_fire = en & in_valid & in_ready.
REQ-005 The block SHALL define out_fire = en & out_valid & out_ready.
REQ-006 The block SHALL hold a main entry driving out_data/out_valid and a skid entry, giving states EMPTY (occ=0), ONE (occ=1) and TWO (occ=2).
REQ-007 The block SHALL go EMPTY -> ONE on in_fire, with in_data loading main.
REQ-008 In ONE, the block SHALL behave as follows:
- in_fire & !out_fire: go to TWO, in_data loads skid.
- in_fire & out_fire: stay ONE, in_data loads main.
- !in_fire & out_fire: go to EMPTY.
REQ-009 In TWO, the block SHALL move skid to main and go to ONE on out_fire; in_fire is impossible in TWO.
REQ-010 The block SHALL drive in_ready = (state != TWO), registered from the next-state value, so in_ready never depends combinationally on out_ready.
REQ-011 The block SHALL have a latency of 1 cycle: in_fire at edge N makes out_valid=1 with that data after edge N when the block was EMPTY.
REQ-012 The block SHALL preserve order: entries leave in acceptance order, with none lost or duplicated.
REQ-013 With en=0, the block SHALL hold all registers and no transfer SHALL occur, regardless of in_valid/out_ready.
REQ-014 On flush=1 at an edge, the block SHALL go to EMPTY, set out_valid=0, out_data=RST_VAL, occ=0 and in_ready=1, drop any in_fire of that cycle, and treat any out_fire of that cycle as consumed.
REQ-015 flush SHALL take priority over en and over every handshake.
REQ-016 The block SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-017 While rst=0 at a rising edge, the block SHALL set state=EMPTY, out_valid=0, out_data=RST_VAL, skid data=RST_VAL, in_ready=1, occ=0 and stall_cnt=0.
REQ-018 Reset SHALL take priority over flush and en, and an entry in flight during reset SHALL be discarded.

Configuration
REQ-019 With macro PIPE_SKID_STALL_CNT_EN defined, stall_cnt SHALL increment on each edge where en & out_valid & !out_ready, saturate at 32'hFFFF_FFFF, and clear only on reset, not on flush.
REQ-020 Without PIPE_SKID_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Package pipe_pkg SHALL hold the state enumeration (EMPTY/ONE/TWO) and the default width constant PIPE_DATA_W=32.
REQ-022 The saturating counter SHALL be sub-module pipe_sat_ctr (width parameter, inc, clear), instantiated only under the macro.
REQ-023 The state machine and datapath SHALL be implemented inline, with no further sub-modules.

Verification
REQ-024 The bench SHALL cover streaming: in_valid=1 and out_ready=1 constantly, in_data=1,2,3,... -> out_data 1,2,3,... one per cycle from cycle 1, with occ=1 throughout.
REQ-025 The bench SHALL cover backpressure: accept 0xA then 0xB with out_ready=0 -> occ=2 and in_ready=0; then out_ready=1 -> 0xA, then 0xB, with in_ready=1 one cycle after the first out_fire.
REQ-026 The bench SHALL cover flush in TWO: flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=RST_VAL, occ=0, and the offered word never appears.
REQ-027 The bench SHALL cover freeze: en=0 for 5 cycles with in_valid=1 and out_ready=1 -> out_data, occ and in_ready unchanged, and zero transfers.
REQ-028 The bench SHALL cover reset mid-operation: occ=2, then rst=0 for 1 cycle -> occ=0, out_valid=0 and in_ready=1, with no old data emerging afterwards.
REQ-029 The bench SHALL cover the counter: with the macro, out_valid=1 and out_ready=0 for 7 cycles -> stall_cnt=7; a flush leaves 7; a preload of 0xFFFF_FFFE followed by 3 stall cycles -> 0xFFFF_FFFF.
